writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
// - Final pipeline stage, directly downstream of memory_stage: MEM/WB pipeline register, load-data
//   extraction/extension from synchronous data SRAM, register-file write port, retire counter.
// - Sources the forwarding buses memory_stage consumes: forward_wb_* (current retire) and
//   forward_wb_*_reg (retire one cycle earlier).
// PARAMETERS
// - PC_W      32  width of pc / debug pc
// - CNT_W     32  width of retired-instruction counter (wraps)
// PORTS
// - clk                  in   1      clock; all state updates on posedge
// - reset                in   1      synchronous, active-high reset
// - mem_to_wb_valid      in   1      memory stage presents a valid instruction
// - wb_allowin           out  1      WB can accept this cycle = !wb_valid | !wb_stall
// - wb_stall             in   1      external hold of WB (instruction stays, no retire)
// - mem_pc               in   PC_W   pc of incoming instruction
// - mem_alu_result       in   32     ALU result / load address (same value as data_sram_addr)
// - mem_rf_wen           in   1      instruction writes a register
// - mem_dest             in   5      destination register number
// - mem_ld_type          in   3      0 none,1 LW,2 LB,3 LBU,4 LH,5 LHU; 6,7 treated as 0
// - data_sram_rdata      in   32     SRAM read data, valid the cycle after the request
// - rf_wen               out  1      register-file write enable
// - rf_waddr             out  5      register-file write address
// - rf_wdata             out  32     register-file write data
// - forward_wb_wen / forward_wb_regsrc / forward_wb_wdata             out 1/5/32  = rf_wen/waddr/wdata
// - forward_wb_wen_reg / forward_wb_regsrc_reg / forward_wb_wdata_reg out 1/5/32  prior-cycle copy
// - debug_wb_pc          out  PC_W   pc of retiring instruction (0 when none)
// - retire_cnt           out  CNT_W  count of retired instructions
// BEHAVIOUR
// - Accept: when mem_to_wb_valid & wb_allowin, latch pc, alu_result, rf_wen, dest, ld_type; wb_valid<=1.
//   When wb_allowin & !mem_to_wb_valid, wb_valid<=0. Otherwise hold everything.
// - Retire: retire = wb_valid & !wb_stall. One instruction retires per cycle, latency 1 cycle from accept.
// - rf_wen = retire & wb_rf_wen & (wb_dest!=0); rf_waddr = wb_dest; rf_wdata = result (below).
// - Load data: rdata_eff = rdata_held ? rdata_hold : data_sram_rdata.
//   On first WB cycle of an instruction (cycle after accept) with wb_stall=1: rdata_hold<=data_sram_rdata,
//   rdata_held<=1. rdata_held clears on every accept and on reset. Data is therefore stable across any stall.
// - Extraction uses latched addr[1:0]: LW whole word; LB/LBU byte addr[1:0]*8, sign/zero extend to 32;
//   LH/LHU half addr[1]*16, addr[0] ignored (alignment faults handled upstream); type 0/6/7 -> alu_result.
// - forward_wb_* are combinational copies of rf_wen/rf_waddr/rf_wdata (same cycle).
// - forward_wb_*_reg register forward_wb_* every cycle (wen_reg=0 if no retire in prior cycle).
// - debug_wb_pc = retire ? wb_pc : 0.
// - retire_cnt increments by 1 on each retire, wraps at 2^CNT_W; counts instructions with rf_wen=0 too.
// - Reset (sync, any time incl. mid-stall): wb_valid=0, rdata_held=0, rdata_hold=0, all latched fields 0,
//   *_reg outputs 0, retire_cnt=0; hence rf_wen=0, debug_wb_pc=0, wb_allowin=1 the cycle after reset.
// - Simultaneous accept+retire: allowed (allowin=1 when !wb_stall); new instruction replaces old same edge.
// - wb_stall with wb_valid=0: no effect; allowin stays 1, accepts proceed.
// STRUCTURE
// - Shared package/defines: LD_NONE..LD_LHU codes (3-bit), shared with decode and memory stages.
// - One sub-module: wb_load_align (comb: ld_type, addr[1:0], rdata, alu_result -> 32-bit result).
// - Top: pipeline register, rdata hold, forwarding delay registers, retire counter.
// TESTING
// - Reset: assert reset 2 cycles during a stalled load -> all outputs 0, wb_allowin=1, retire_cnt=0.
// - ALU write: dest=5, alu=0x1234_5678, ld=0 -> next cycle rf_wen=1, waddr=5, wdata=0x12345678;
//   following cycle forward_wb_wen_reg=1, regsrc_reg=5, wdata_reg=0x12345678.
// - Loads rdata=0x80FF_7F01: LB addr..01 -> 0x0000007F; LB ..10 -> 0xFFFFFFFF... (byte 0xFF);
//   LBU ..11 -> 0x00000080; LH ..10 -> 0xFFFF80FF; LHU ..00 -> 0x00007F01; LW -> 0x80FF7F01.
// - Stalled load: LW, wb_stall=1 for 3 cycles, rdata changes to 0xDEADBEEF after first cycle ->
//   rf_wen=0 while stalled, retires with original data; wb_allowin=0 throughout stall.
// - Dest $0: mem_rf_wen=1, dest=0 -> rf_wen=0, forward_wb_wen=0, retire_cnt still +1, debug pc valid.
// - Back-to-back: 4 instructions on consecutive cycles, no stall -> 4 retires in 4 cycles, retire_cnt=4,
//   forward_wb_*_reg always equals previous cycle's forward_wb_*.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared load-type encodings and extension helpers for the decode/memory/writeback stages.
package writeback_stage_pkg;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LW   = 3'd1;
  localparam logic [2:0] LD_LB   = 3'd2;
  localparam logic [2:0] LD_LBU  = 3'd3;
  localparam logic [2:0] LD_LH   = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB handshake, SRAM read data, register-file write port, forwarding and debug signals.
interface writeback_stage_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             mem_to_wb_valid;
  logic             wb_allowin;
  logic             wb_stall;
  logic [PC_W-1:0]  mem_pc;
  logic [31:0]      mem_alu_result;
  logic             mem_rf_wen;
  logic [4:0]       mem_dest;
  logic [2:0]       mem_ld_type;
  logic [31:0]      data_sram_rdata;
  logic             rf_wen;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             forward_wb_wen;
  logic [4:0]       forward_wb_regsrc;
  logic [31:0]      forward_wb_wdata;
  logic             forward_wb_wen_reg;
  logic [4:0]       forward_wb_regsrc_reg;
  logic [31:0]      forward_wb_wdata_reg;
  logic [PC_W-1:0]  debug_wb_pc;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output mem_to_wb_valid, wb_stall, mem_pc, mem_alu_result, mem_rf_wen, mem_dest,
           mem_ld_type, data_sram_rdata,
    input  wb_allowin, rf_wen, rf_waddr, rf_wdata, forward_wb_wen, forward_wb_regsrc,
           forward_wb_wdata, forward_wb_wen_reg, forward_wb_regsrc_reg, forward_wb_wdata_reg,
           debug_wb_pc, retire_cnt
  );

  modport slave (
    input  mem_to_wb_valid, wb_stall, mem_pc, mem_alu_result, mem_rf_wen, mem_dest,
           mem_ld_type, data_sram_rdata,
    output wb_allowin, rf_wen, rf_waddr, rf_wdata, forward_wb_wen, forward_wb_regsrc,
           forward_wb_wdata, forward_wb_wen_reg, forward_wb_regsrc_reg, forward_wb_wdata_reg,
           debug_wb_pc, retire_cnt
  );
endinterface

// File: rtl/wb_load_align.sv
// Selects and extends load data by type and low address bits; non-loads pass the ALU result.
module wb_load_align
  import writeback_stage_pkg::*;
(
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
    endcase
    // addr[0] is ignored for halfwords; misalignment is trapped upstream.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (ld_type_i)
      LD_LW:   result_o = rdata_i;
      LD_LB:   result_o = ext8(byte_sel, 1'b1);
      LD_LBU:  result_o = ext8(byte_sel, 1'b0);
      LD_LH:   result_o = ext16(half_sel, 1'b1);
      LD_LHU:  result_o = ext16(half_sel, 1'b0);
      default: result_o = alu_result_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, stall-safe load data hold, register-file write,
// forwarding sources (current and one-cycle-delayed) and retire counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave wb_if
);

  logic             wb_valid_q, wb_valid_d;
  logic [PC_W-1:0]  wb_pc_q, wb_pc_d;
  logic [31:0]      wb_alu_q, wb_alu_d;
  logic             wb_rf_wen_q, wb_rf_wen_d;
  logic [4:0]       wb_dest_q, wb_dest_d;
  logic [2:0]       wb_ld_type_q, wb_ld_type_d;
  logic             rdata_held_q, rdata_held_d;
  logic [31:0]      rdata_hold_q, rdata_hold_d;
  logic             fwd_wen_reg_q, fwd_wen_reg_d;
  logic [4:0]       fwd_regsrc_reg_q, fwd_regsrc_reg_d;
  logic [31:0]      fwd_wdata_reg_q, fwd_wdata_reg_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic        allowin, accept, retire, rf_wen;
  logic [31:0] rdata_eff, result;

  wb_load_align u_load_align (
    .ld_type_i    (wb_ld_type_q),
    .addr_lo_i    (wb_alu_q[1:0]),
    .rdata_i      (rdata_eff),
    .alu_result_i (wb_alu_q),
    .result_o     (result)
  );

  always_comb begin
    allowin   = !wb_valid_q | !wb_if.wb_stall;
    accept    = wb_if.mem_to_wb_valid & allowin;
    retire    = wb_valid_q & !wb_if.wb_stall;
    rf_wen    = retire & wb_rf_wen_q & (wb_dest_q != 5'd0);
    rdata_eff = rdata_held_q ? rdata_hold_q : wb_if.data_sram_rdata;

    wb_valid_d   = wb_valid_q;
    wb_pc_d      = wb_pc_q;
    wb_alu_d     = wb_alu_q;
    wb_rf_wen_d  = wb_rf_wen_q;
    wb_dest_d    = wb_dest_q;
    wb_ld_type_d = wb_ld_type_q;
    rdata_held_d = rdata_held_q;
    rdata_hold_d = rdata_hold_q;

    if (accept) begin
      wb_valid_d   = 1'b1;
      wb_pc_d      = wb_if.mem_pc;
      wb_alu_d     = wb_if.mem_alu_result;
      wb_rf_wen_d  = wb_if.mem_rf_wen;
      wb_dest_d    = wb_if.mem_dest;
      wb_ld_type_d = wb_if.mem_ld_type;
      rdata_held_d = 1'b0;
    end else if (allowin) begin
      wb_valid_d = 1'b0;
    end else if (!rdata_held_q) begin
      // SRAM data is only valid the cycle after the request; capture it on the first stall.
      rdata_held_d = 1'b1;
      rdata_hold_d = wb_if.data_sram_rdata;
    end

    fwd_wen_reg_d    = rf_wen;
    fwd_regsrc_reg_d = wb_dest_q;
    fwd_wdata_reg_d  = result;
    retire_cnt_d     = retire_cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q       <= 1'b0;
      wb_pc_q          <= '0;
      wb_alu_q         <= '0;
      wb_rf_wen_q      <= 1'b0;
      wb_dest_q        <= '0;
      wb_ld_type_q     <= LD_NONE;
      rdata_held_q     <= 1'b0;
      rdata_hold_q     <= '0;
      fwd_wen_reg_q    <= 1'b0;
      fwd_regsrc_reg_q <= '0;
      fwd_wdata_reg_q  <= '0;
      retire_cnt_q     <= '0;
    end else begin
      wb_valid_q       <= wb_valid_d;
      wb_pc_q          <= wb_pc_d;
      wb_alu_q         <= wb_alu_d;
      wb_rf_wen_q      <= wb_rf_wen_d;
      wb_dest_q        <= wb_dest_d;
      wb_ld_type_q     <= wb_ld_type_d;
      rdata_held_q     <= rdata_held_d;
      rdata_hold_q     <= rdata_hold_d;
      fwd_wen_reg_q    <= fwd_wen_reg_d;
      fwd_regsrc_reg_q <= fwd_regsrc_reg_d;
      fwd_wdata_reg_q  <= fwd_wdata_reg_d;
      retire_cnt_q     <= retire_cnt_d;
    end
  end

  assign wb_if.wb_allowin            = allowin;
  assign wb_if.rf_wen                = rf_wen;
  assign wb_if.rf_waddr              = wb_dest_q;
  assign wb_if.rf_wdata              = result;
  assign wb_if.forward_wb_wen        = rf_wen;
  assign wb_if.forward_wb_regsrc     = wb_dest_q;
  assign wb_if.forward_wb_wdata      = result;
  assign wb_if.forward_wb_wen_reg    = fwd_wen_reg_q;
  assign wb_if.forward_wb_regsrc_reg = fwd_regsrc_reg_q;
  assign wb_if.forward_wb_wdata_reg  = fwd_wdata_reg_q;
  assign wb_if.debug_wb_pc           = retire ? wb_pc_q : '0;
  assign wb_if.retire_cnt            = retire_cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset mid-stall, ALU write, load extraction, stalled load,
// $0 destination, idle stall and back-to-back retirement.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  writeback_stage_if #(.PC_W(32), .CNT_W(32)) wb_if ();

  writeback_stage #(.PC_W(32), .CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .wb_if (wb_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic wen,
                      input logic [4:0] dest, input logic [2:0] ld);
    wb_if.mem_to_wb_valid = 1'b1;
    wb_if.mem_pc          = pc;
    wb_if.mem_alu_result  = alu;
    wb_if.mem_rf_wen      = wen;
    wb_if.mem_dest        = dest;
    wb_if.mem_ld_type     = ld;
  endtask

  task automatic do_load(input string tag, input logic [2:0] ld, input logic [1:0] lo,
                         input logic [31:0] exp);
    send(32'h600, {30'h0400_0000, lo}, 1'b1, 5'd7, ld);
    tick();
    wb_if.mem_to_wb_valid = 1'b0;
    wb_if.data_sram_rdata = 32'h80FF_7F01;
    settle();
    chk(tag, wb_if.rf_wdata, exp);
    chkb({tag, "_wen"}, wb_if.rf_wen, 1'b1);
    tick();
    exp_cnt++;
    settle();
    chk({tag, "_cnt"}, wb_if.retire_cnt, exp_cnt);
  endtask

  initial begin
    reset                 = 1'b1;
    wb_if.mem_to_wb_valid = 1'b0;
    wb_if.wb_stall        = 1'b0;
    wb_if.mem_pc          = '0;
    wb_if.mem_alu_result  = '0;
    wb_if.mem_rf_wen      = 1'b0;
    wb_if.mem_dest        = '0;
    wb_if.mem_ld_type     = LD_NONE;
    wb_if.data_sram_rdata = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset asserted for two cycles while a load is stalled in WB.
    send(32'h100, 32'h10, 1'b1, 5'd3, LD_LW);
    tick();
    wb_if.mem_to_wb_valid = 1'b0;
    wb_if.wb_stall        = 1'b1;
    wb_if.data_sram_rdata = 32'h1111_1111;
    settle();
    chkb("pre_rst_allowin", wb_if.wb_allowin, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    chkb("rst_allowin", wb_if.wb_allowin, 1'b1);
    chkb("rst_rf_wen", wb_if.rf_wen, 1'b0);
    chk("rst_waddr", 32'(wb_if.rf_waddr), 32'd0);
    chk("rst_wdata", wb_if.rf_wdata, 32'd0);
    chk("rst_dbg_pc", wb_if.debug_wb_pc, 32'd0);
    chk("rst_cnt", wb_if.retire_cnt, 32'd0);
    chkb("rst_wen_reg", wb_if.forward_wb_wen_reg, 1'b0);
    chk("rst_regsrc_reg", 32'(wb_if.forward_wb_regsrc_reg), 32'd0);
    chk("rst_wdata_reg", wb_if.forward_wb_wdata_reg, 32'd0);
    wb_if.wb_stall = 1'b0;

    // ALU write.
    send(32'h200, 32'h1234_5678, 1'b1, 5'd5, LD_NONE);
    tick();
    wb_if.mem_to_wb_valid = 1'b0;
    settle();
    chkb("alu_rf_wen", wb_if.rf_wen, 1'b1);
    chk("alu_waddr", 32'(wb_if.rf_waddr), 32'd5);
    chk("alu_wdata", wb_if.rf_wdata, 32'h1234_5678);
    chkb("alu_fwd_wen", wb_if.forward_wb_wen, 1'b1);
    chk("alu_fwd_wdata", wb_if.forward_wb_wdata, 32'h1234_5678);
    chk("alu_dbg_pc", wb_if.debug_wb_pc, 32'h200);
    chk("alu_cnt0", wb_if.retire_cnt, 32'd0);
    tick();
    exp_cnt = 1;
    settle();
    chkb("alu_wen_reg", wb_if.forward_wb_wen_reg, 1'b1);
    chk("alu_regsrc_reg", 32'(wb_if.forward_wb_regsrc_reg), 32'd5);
    chk("alu_wdata_reg", wb_if.forward_wb_wdata_reg, 32'h1234_5678);
    chk("alu_cnt1", wb_if.retire_cnt, 32'd1);
    chkb("alu_idle_wen", wb_if.rf_wen, 1'b0);
    chk("alu_idle_pc", wb_if.debug_wb_pc, 32'd0);

    // Load extraction from 0x80FF7F01.
    do_load("lb_01", LD_LB, 2'b01, 32'h0000_007F);
    do_load("lb_10", LD_LB, 2'b10, 32'hFFFF_FFFF);
    do_load("lb_11", LD_LB, 2'b11, 32'hFFFF_FF80);
    do_load("lbu_11", LD_LBU, 2'b11, 32'h0000_0080);
    do_load("lh_10", LD_LH, 2'b10, 32'hFFFF_80FF);
    do_load("lhu_00", LD_LHU, 2'b00, 32'h0000_7F01);
    do_load("lhu_11", LD_LHU, 2'b11, 32'h0000_80FF);
    do_load("lw_00", LD_LW, 2'b00, 32'h80FF_7F01);
    do_load("ld6_alu", 3'd6, 2'b01, 32'h1000_0001);

    // Stalled load; a younger instruction waits in MEM and enters as the load retires.
    send(32'h300, 32'h2000, 1'b1, 5'd9, LD_LW);
    tick();
    send(32'h380, 32'hAAAA_0000, 1'b1, 5'd10, LD_NONE);
    wb_if.wb_stall        = 1'b1;
    wb_if.data_sram_rdata = 32'h0102_0304;
    settle();
    chkb("stl1_wen", wb_if.rf_wen, 1'b0);
    chkb("stl1_allowin", wb_if.wb_allowin, 1'b0);
    chk("stl1_pc", wb_if.debug_wb_pc, 32'd0);
    tick();
    wb_if.data_sram_rdata = 32'hDEAD_BEEF;
    settle();
    chkb("stl2_wen", wb_if.rf_wen, 1'b0);
    chkb("stl2_allowin", wb_if.wb_allowin, 1'b0);
    chk("stl2_wdata", wb_if.rf_wdata, 32'h0102_0304);
    tick();
    settle();
    chkb("stl3_allowin", wb_if.wb_allowin, 1'b0);
    chk("stl3_wdata", wb_if.rf_wdata, 32'h0102_0304);
    tick();
    wb_if.wb_stall = 1'b0;
    settle();
    chkb("stl_ret_wen", wb_if.rf_wen, 1'b1);
    chk("stl_ret_waddr", 32'(wb_if.rf_waddr), 32'd9);
    chk("stl_ret_wdata", wb_if.rf_wdata, 32'h0102_0304);
    chk("stl_ret_pc", wb_if.debug_wb_pc, 32'h300);
    chkb("stl_ret_allowin", wb_if.wb_allowin, 1'b1);
    tick();
    wb_if.mem_to_wb_valid = 1'b0;
    settle();
    chk("swap_pc", wb_if.debug_wb_pc, 32'h380);
    chk("swap_waddr", 32'(wb_if.rf_waddr), 32'd10);
    chk("swap_wdata", wb_if.rf_wdata, 32'hAAAA_0000);
    chkb("swap_wen_reg", wb_if.forward_wb_wen_reg, 1'b1);
    chk("swap_wdata_reg", wb_if.forward_wb_wdata_reg, 32'h0102_0304);
    tick();
    exp_cnt += 2;
    settle();
    chk("stl_cnt", wb_if.retire_cnt, exp_cnt);

    // Destination $0 retires without a register write.
    send(32'h400, 32'h55, 1'b1, 5'd0, LD_NONE);
    tick();
    wb_if.mem_to_wb_valid = 1'b0;
    settle();
    chkb("r0_wen", wb_if.rf_wen, 1'b0);
    chkb("r0_fwd_wen", wb_if.forward_wb_wen, 1'b0);
    chk("r0_pc", wb_if.debug_wb_pc, 32'h400);
    tick();
    exp_cnt++;
    settle();
    chk("r0_cnt", wb_if.retire_cnt, exp_cnt);
    chkb("r0_wen_reg", wb_if.forward_wb_wen_reg, 1'b0);

    // Stall with an empty stage must not block an accept.
    wb_if.wb_stall = 1'b1;
    settle();
    chkb("idle_stl_allowin", wb_if.wb_allowin, 1'b1);
    send(32'h440, 32'h77, 1'b1, 5'd4, LD_NONE);
    tick();
    wb_if.mem_to_wb_valid = 1'b0;
    settle();
    chkb("idle_stl_held", wb_if.wb_allowin, 1'b0);
    chkb("idle_stl_wen", wb_if.rf_wen, 1'b0);
    wb_if.wb_stall = 1'b0;
    settle();
    chkb("idle_rel_wen", wb_if.rf_wen, 1'b1);
    chk("idle_rel_wdata", wb_if.rf_wdata, 32'h77);
    tick();

    // Back-to-back retirement after a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'(32'h500 + 4 * i), 32'(32'h1000 + i), 1'b1, 5'(i + 1), LD_NONE);
      tick();
      settle();
      chkb("b2b_wen", wb_if.rf_wen, 1'b1);
      chk("b2b_waddr", 32'(wb_if.rf_waddr), 32'(i + 1));
      chk("b2b_wdata", wb_if.rf_wdata, 32'(32'h1000 + i));
      chk("b2b_pc", wb_if.debug_wb_pc, 32'(32'h500 + 4 * i));
      chk("b2b_cnt", wb_if.retire_cnt, 32'(i));
      if (i > 0) begin
        chkb("b2b_wen_reg", wb_if.forward_wb_wen_reg, 1'b1);
        chk("b2b_regsrc_reg", 32'(wb_if.forward_wb_regsrc_reg), 32'(i));
        chk("b2b_wdata_reg", wb_if.forward_wb_wdata_reg, 32'(32'h1000 + i - 1));
      end
    end
    wb_if.mem_to_wb_valid = 1'b0;
    tick();
    settle();
    chk("b2b_cnt_final", wb_if.retire_cnt, 32'd4);
    chk("b2b_wdata_reg_final", wb_if.forward_wb_wdata_reg, 32'h1003);
    chkb("b2b_idle_wen", wb_if.rf_wen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
